// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data bus.
// DATA (BASE_ADDR) queues a byte into a small FIFO; STATUS (BASE_ADDR+1)
// reports {overflow, busy, full} and a write to it clears overflow.
// The line is driven from a flop and lags the FSM state by one cycle, so the
// start bit falls on the edge after the FIFO pop.
module mmio_uart_tx #(
   parameter int          CLK_HZ     = 12000000,
   parameter int          BAUD       = 115200,
   parameter logic [15:0] BASE_ADDR  = 16'h6002,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [15:0] in,
   input  logic        load,
   output logic [15:0] out,
   output logic        sel,
   output logic        tx
);

   localparam int          DIV       = CLK_HZ / BAUD;
   localparam int          CW        = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int          AW        = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);
   localparam logic [15:0]   STAT_ADDR = BASE_ADDR + 16'd1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // serializer state
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;

   // register file
   logic            ovf_q, ovf_d;
   logic [7:0]      last_q, last_d;

   // transmit FIFO
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;

   logic            wr_data, wr_stat;
   logic            full, empty, busy;
   logic            push, pop;
   logic            baud_done;

   assign wr_data   = load && (address == BASE_ADDR);
   assign wr_stat   = load && (address == STAT_ADDR);
   assign full      = (count_q == CNT_FULL);
   assign empty     = (count_q == '0);
   assign busy      = (state_q != S_IDLE) || !empty;
   // full is sampled before any pop on the same edge, so a write to a full
   // FIFO is dropped even while the serializer is taking the head.
   assign push      = wr_data && !full;
   assign baud_done = (cnt_q == CNT_LAST);
   assign sel       = (address == BASE_ADDR) || (address == STAT_ADDR);
   assign tx        = tx_q;

   // combinational read mux: the CPU samples inM in the same cycle
   always_comb begin
      out = '0;
      if (address == STAT_ADDR) begin
         out = {13'b0, ovf_q, busy, full};
      end else if (address == BASE_ADDR) begin
         out = {8'b0, last_q};
      end
   end

   // register updates: last byte written and sticky overflow (clear wins)
   always_comb begin
      last_d = last_q;
      ovf_d  = ovf_q;
      if (wr_data) begin
         last_d = in[7:0];
      end
      if (wr_stat) begin
         ovf_d = 1'b0;
      end else if (wr_data && full) begin
         ovf_d = 1'b1;
      end
   end

   // FIFO next state: pointers wrap naturally, count separates full/empty
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = in[7:0];
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // serializer FSM: IDLE pops, then START/DATA x8/STOP, each DIV cycles;
   // tx_d follows the current state so the line lags the state by one cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = 1'b1;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               cnt_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (baud_done) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            tx_d = shift_q[0];
            if (baud_done) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (baud_done) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // state registers; reset aborts any frame and forces the line high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= 3'd0;
         shift_q  <= 8'h00;
         tx_q     <= 1'b1;
         ovf_q    <= 1'b0;
         last_q   <= 8'h00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         ovf_q    <= ovf_d;
         last_q   <= last_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with DIV=4. Stimulus pushes the bytes it expects on
// the line into exp_q; an independent serial monitor captures each frame
// (40 samples, one per cycle) and compares it against the popped byte.
module tb_mmio_uart_tx;

   localparam logic [15:0] DATA_A = 16'h6002;
   localparam logic [15:0] STAT_A = 16'h6003;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] address = 16'h0000;
   logic [15:0] in = 16'h0000;
   logic        load = 1'b0;
   logic [15:0] out;
   logic        sel;
   logic        tx;

   mmio_uart_tx #(
      .CLK_HZ(400), .BAUD(100), .BASE_ADDR(16'h6002), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .in(in), .load(load),
      .out(out), .sel(sel), .tx(tx)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int frames = 0;
   int prev_end = 0;
   int last_gap = -1;
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // serial monitor: a frame begins at the first negedge where tx is low
   initial begin
      logic [39:0] samp, ev;
      logic [9:0]  fr;
      logic [7:0]  e;
      bit          abort;
      forever begin
         @(negedge clk);
         if (!reset && tx === 1'b0) begin
            last_gap = cyc - prev_end - 1;
            samp = '0;
            samp[0] = tx;
            abort = 0;
            for (int k = 1; k < 40; k++) begin
               @(negedge clk);
               if (reset) begin
                  abort = 1;
                  break;
               end
               samp[k] = tx;
            end
            if (!abort) begin
               prev_end = cyc;
               frames++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", samp, 40'h0);
               end else begin
                  e  = exp_q.pop_front();
                  fr = {1'b1, e, 1'b0};
                  for (int i = 0; i < 10; i++)
                     for (int k = 0; k < 4; k++) ev[i*4+k] = fr[i];
                  chk($sformatf("frame_%02h", e), samp, ev);
               end
            end
         end
      end
   end

   // one bus write per call; entered and left on a negedge
   task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit expect_tx);
      address = a;
      in = d;
      load = 1'b1;
      if (expect_tx) exp_q.push_back(d[7:0]);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
      load = 1'b0;
      address = a;
      #1;
      chk(name, out, exp);
   endtask

   task automatic sel_at(input logic [15:0] a, input logic exp, input string name);
      address = a;
      #1;
      chk(name, sel, exp);
   endtask

   task automatic wait_idle(input int maxc, input string name);
      bit done = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         load = 1'b0;
         address = STAT_A;
         #1;
         if (out == 16'h0000 && exp_q.size() == 0) begin
            done = 1;
            break;
         end
      end
      chk(name, done, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int f0;
      int lows;
      bit seen;

      // reset values
      repeat (3) @(negedge clk);
      chk("tx_in_reset", tx, 1);
      reset = 1'b0;
      rd(STAT_A, 16'h0000, "status_reset");
      rd(DATA_A, 16'h0000, "data_reset");
      sel_at(16'h6002, 1'b1, "sel_6002");
      sel_at(16'h6003, 1'b1, "sel_6003");
      sel_at(16'h6001, 1'b0, "sel_6001");
      sel_at(16'h6004, 1'b0, "sel_6004");

      // single byte 0xA5: tx stays high through the pop edge, falls after it
      @(negedge clk);
      wr(DATA_A, 16'h00A5, 1);
      rd(STAT_A, 16'h0002, "busy_after_write");
      chk("tx_before_pop", tx, 1);
      @(negedge clk); #1;
      chk("tx_at_pop_edge", tx, 1);
      @(negedge clk); #1;
      chk("tx_start_bit", tx, 0);
      repeat (20) @(negedge clk);
      rd(STAT_A, 16'h0002, "busy_mid_frame");
      wait_idle(100, "single_idle");
      rd(STAT_A, 16'h0000, "status_after_single");

      // back-to-back: one idle cycle between frames
      wr(DATA_A, 16'h0055, 1);
      wr(DATA_A, 16'h000F, 1);
      wait_idle(200, "b2b_idle");
      chk("b2b_gap", last_gap, 1);

      // overflow: 6 writes, 6th dropped; clear; full until the next pop
      f0 = frames;
      wr(DATA_A, 16'h0011, 1);
      wr(DATA_A, 16'h0022, 1);
      wr(DATA_A, 16'h0033, 1);
      wr(DATA_A, 16'h0044, 1);
      wr(DATA_A, 16'h0055, 1);
      wr(DATA_A, 16'h0066, 0);
      rd(STAT_A, 16'h0007, "ovf_set");
      wr(STAT_A, 16'hFFFF, 0);
      rd(STAT_A, 16'h0003, "ovf_clear_full");
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (frames == f0 + 1) begin
            seen = 1;
            break;
         end
      end
      chk("first_ovf_frame_seen", seen, 1);
      rd(STAT_A, 16'h0003, "full_until_pop");
      @(negedge clk);
      rd(STAT_A, 16'h0002, "not_full_after_pop");
      wait_idle(400, "ovf_idle");
      chk("ovf_frame_count", frames - f0, 5);

      // reset during data bit 3 with two bytes queued
      wr(DATA_A, 16'h0000, 1);
      wr(DATA_A, 16'h0081, 1);
      wr(DATA_A, 16'h0042, 1);
      repeat (17) @(negedge clk);
      chk("tx_bit3_low", tx, 0);
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("tx_async_reset", tx, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      lows = 0;
      repeat (80) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("no_frame_after_reset", lows, 0);
      rd(STAT_A, 16'h0000, "status_after_reset");
      rd(DATA_A, 16'h0000, "data_after_reset");

      // readback of the last byte written
      @(negedge clk);
      wr(DATA_A, 16'h1234, 1);
      rd(DATA_A, 16'h0034, "readback_data");
      rd(16'h0000, 16'h0000, "out_other_addr");
      chk("sel_other_addr", sel, 0);
      wait_idle(100, "readback_idle");
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. It is the responder to the CPU's data-memory bus (address/in/load/out), the output-direction counterpart of the board's input pins.
- Decodes two word addresses: DATA (write a byte to send) and STATUS (read/clear flags).
- Bytes are buffered in a small FIFO and shifted out serially as 8N1 on a single TX pin.
- Sits beside the Memory block. Its out is muxed onto the CPU's inM when sel is high.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate. DIV = CLK_HZ/BAUD (integer division), must be >= 2.
- BASE_ADDR, 16'h6002, DATA register address. STATUS is at BASE_ADDR+1.
- FIFO_DEPTH, 4, transmit FIFO entries. Power of two, >= 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  16  CPU data address (addressM).
- in  input  16  CPU write data (outM). Only in[7:0] is used.
- load  input  1  CPU write strobe (writeM).
- out  output  16  read data, combinational.
- sel  output  1  combinational, high when address == BASE_ADDR or BASE_ADDR+1.
- tx  output  1  serial line. Idle high.

Behaviour:
- Reset (asynchronous):
  - FIFO emptied; FSM to IDLE; baud counter and bit index cleared; overflow cleared.
  - tx = 1, registered.
  - Reset mid-frame aborts the frame; tx goes high immediately.
- Read path, combinational, same cycle (the CPU samples inM without a wait state):
  - address == BASE_ADDR+1: out = {13'b0, overflow, busy, full}.
  - address == BASE_ADDR: out = {8'b0, last byte written}. Register cleared by reset.
  - Any other address: out = 0.
- Flag definitions:
  - full = FIFO count == FIFO_DEPTH.
  - busy = FSM != IDLE or FIFO count != 0.
  - overflow: sticky.
- Write to DATA (load=1, address==BASE_ADDR):
  - If full was 0 in that cycle, push in[7:0].
  - If full was 1, drop the byte and set overflow. This holds even if a pop occurs on the same edge; full is evaluated before the pop.
- Write to STATUS (load=1, address==BASE_ADDR+1) with any data: clears overflow. If a DATA overflow cannot coincide, clearing takes priority.
- FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..DIV-1.
  - IDLE: tx=1. If FIFO non-empty, pop the head into the shift register, clear the counter, go to START.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for DIV cycles, then shift right. After bit index 7 completes, go to STOP. LSB first.
  - STOP: tx=1 for DIV cycles, then go to IDLE.
- Frame timing:
  - tx falls on the first clock edge after the pop edge.
  - Frame = 10*DIV cycles.
  - Back-to-back frames are separated by exactly 1 idle cycle (tx=1, IDLE re-evaluates).
- Simultaneous push and pop when not full: both happen; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count is tracked to distinguish full from empty.
- tx is driven from a flop (glitch-free).

Test Plan:
- Reset values:
  - Stimulus: hold reset, then release.
  - Required: tx=1; out at STATUS = 0x0000; sel=1 only at 0x6002 and 0x6003 (0 at 0x6001 and 0x6004).
- Single byte (CLK_HZ=400, BAUD=100, so DIV=4):
  - Stimulus: write 0x00A5 to 0x6002.
  - Required: tx, 4 cycles per bit, = 0,1,0,1,0,0,1,0,1,1 starting one cycle after the pop edge.
  - Required: busy=1 during the frame; STATUS returns to 0x0000 after the stop bit.
- Back-to-back bytes:
  - Stimulus: write 0x55 then 0x0F on consecutive cycles.
  - Required: two frames with exactly one idle tx=1 cycle between the stop bit and the next start bit; bit order LSB first.
- Overflow (FIFO_DEPTH=4):
  - Stimulus: write 6 bytes on consecutive cycles while the first frame is starting.
  - Required: the 6th byte is dropped and STATUS bit2=1; full=1 until the next pop.
  - Then write STATUS: overflow clears to 0. Exactly 5 frames are transmitted.
- Reset mid-frame:
  - Stimulus: assert reset during DATA bit 3 with 2 bytes queued.
  - Required: tx=1 asynchronously; after release, no further frames and STATUS = 0.
- Readback:
  - Stimulus: write 0x1234 to DATA.
  - Required: reading DATA gives 0x0034; reading address 0x0000 gives out=0 and sel=0.
